// File: rtl/sift_fifo_reader_pkg.sv
// Shared types and defaults for the SIFT detection FIFO reader.
// Optional partial-drain support is enabled with SIFT_FIFO_READER_FLUSH_EN.
package sift_fifo_reader_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    READ    = 2'd1,
    LAST    = 2'd2,
    PRESENT = 2'd3
  } state_t;

  localparam int WORD_W_DEF    = 16;
  localparam int BURST_LEN_DEF = 16;

  // Integer ceiling division, used to size a flush burst in words.
  function automatic int unsigned ceil_div(input int unsigned num, input int unsigned den);
    return (num + den - 1) / den;
  endfunction

endpackage

// File: rtl/sift_bit_packer.sv
// Packs detection bits MSB-first into a word; bits beyond WORD_W are dropped
// and any bits never received leave zeros in the LSBs.
module sift_bit_packer
  import sift_fifo_reader_pkg::*;
#(
  parameter int WORD_W = WORD_W_DEF
) (
  input  logic              iclk,
  input  logic              ireset,
  input  logic              clear,
  input  logic              shift_en,
  input  logic              bit_in,
  output logic [WORD_W-1:0] word
);

  localparam int CNT_W = $clog2(WORD_W + 1);

  logic [CNT_W-1:0]  bit_cnt;
  logic [WORD_W-1:0] word_next;
  logic              room;

  assign room = bit_cnt < CNT_W'(WORD_W);

  // NOTE: default assignment first keeps this always_comb latch-free.
  always_comb begin
    word_next = word;
    for (int i = 0; i < WORD_W; i++) begin
      if (bit_cnt == CNT_W'(WORD_W - 1 - i)) word_next[i] = bit_in;
    end
  end

  always_ff @(posedge iclk or negedge ireset) begin
    if (!ireset) begin
      word    <= '0;
      bit_cnt <= '0;
    end else if (clear) begin
      word    <= '0;
      bit_cnt <= '0;
    end else if (shift_en && room) begin
      word    <= word_next;
      bit_cnt <= bit_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/sift_detection_fifo_reader.sv
// Drains the detection FIFO in bursts of BURST_LEN packed words.
// Define SIFT_FIFO_READER_FLUSH_EN to add the iflush partial-drain port.
module sift_detection_fifo_reader
  import sift_fifo_reader_pkg::*;
#(
  parameter int WORD_W    = WORD_W_DEF,
  parameter int BURST_LEN = BURST_LEN_DEF,
  parameter int USEDW_W   = 15
) (
  input  logic               iclk,
  input  logic               ireset,
  input  logic [USEDW_W-1:0] iusedw,
  output logic               oread_en,
  input  logic               idata_en,
  input  logic               idata,
  output logic [WORD_W-1:0]  oword,
  output logic               ovalid,
  input  logic               iready,
  output logic               obusy
`ifdef SIFT_FIFO_READER_FLUSH_EN
  ,
  input  logic               iflush
`endif
);

  localparam int              WC_W        = $clog2(BURST_LEN + 1);
  localparam int              BT_W        = $clog2(WORD_W + 1);
  localparam logic [31:0]     THRESH      = 32'(BURST_LEN * WORD_W);
  localparam logic [BT_W-1:0] FULL_TARGET = BT_W'(WORD_W);

  state_t          state;
  logic [WC_W-1:0] word_cnt, word_cnt_dec, start_words;
  logic [BT_W-1:0] bit_target, rd_cnt, start_target, next_target;
  logic [31:0]     usedw_ext;
  logic            start_full, start_flush, more_words, pack_clear, pack_shift;

  assign usedw_ext    = 32'(iusedw);
  assign start_full   = (state == IDLE) && (usedw_ext >= THRESH);
  assign word_cnt_dec = word_cnt - WC_W'(1);
  assign more_words   = word_cnt_dec != '0;

`ifdef SIFT_FIFO_READER_FLUSH_EN
  logic            flush_mode;
  logic [BT_W-1:0] last_bits, flush_rem, last_bits_new;
  logic [WC_W-1:0] flush_words;

  assign flush_words   = WC_W'(ceil_div(usedw_ext, WORD_W));
  assign flush_rem     = BT_W'(usedw_ext % 32'(WORD_W));
  assign last_bits_new = (flush_rem == '0) ? FULL_TARGET : flush_rem;
  assign start_flush   = (state == IDLE) && !start_full && iflush && (usedw_ext != '0);
  assign start_words   = start_full ? WC_W'(BURST_LEN) : flush_words;
  assign start_target  = (start_full || flush_words != WC_W'(1)) ? FULL_TARGET : last_bits_new;
  // Only the final word of a flush burst can be short.
  assign next_target   = (flush_mode && word_cnt_dec == WC_W'(1)) ? last_bits : FULL_TARGET;

  always_ff @(posedge iclk or negedge ireset) begin
    if (!ireset) begin
      flush_mode <= 1'b0;
      last_bits  <= '0;
    end else if (start_full) begin
      flush_mode <= 1'b0;
    end else if (start_flush) begin
      flush_mode <= 1'b1;
      last_bits  <= last_bits_new;
    end
  end
`else
  assign start_flush  = 1'b0;
  assign start_words  = WC_W'(BURST_LEN);
  assign start_target = FULL_TARGET;
  assign next_target  = FULL_TARGET;
`endif

  // NOTE: non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge iclk or negedge ireset) begin
    if (!ireset) begin
      state      <= IDLE;
      oread_en   <= 1'b0;
      word_cnt   <= '0;
      bit_target <= '0;
      rd_cnt     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start_full || start_flush) begin
            state      <= READ;
            oread_en   <= 1'b1;
            word_cnt   <= start_words;
            bit_target <= start_target;
            rd_cnt     <= BT_W'(1);
          end
        end
        READ: begin
          if (rd_cnt == bit_target) begin
            oread_en <= 1'b0;
            state    <= LAST;
          end else begin
            rd_cnt <= rd_cnt + BT_W'(1);
          end
        end
        LAST: state <= PRESENT;
        PRESENT: begin
          if (iready) begin
            word_cnt <= word_cnt_dec;
            if (more_words) begin
              state      <= READ;
              oread_en   <= 1'b1;
              bit_target <= next_target;
              rd_cnt     <= BT_W'(1);
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // A fresh word starts whenever READ is entered; late pulses cannot disturb a presented word.
  assign pack_clear = ((state == IDLE) && (start_full || start_flush)) ||
                      ((state == PRESENT) && iready && more_words);
  assign pack_shift = idata_en && ((state == READ) || (state == LAST));

  sift_bit_packer #(
    .WORD_W (WORD_W)
  ) u_packer (
    .iclk     (iclk),
    .ireset   (ireset),
    .clear    (pack_clear),
    .shift_en (pack_shift),
    .bit_in   (idata),
    .word     (oword)
  );

  assign ovalid = (state == PRESENT);
  assign obusy  = (state != IDLE);

endmodule

// File: tb/tb_sift_detection_fifo_reader.sv
// Self-checking bench for sift_detection_fifo_reader: vector table, hand sequences
// and randomized bursts against a word-level reference model.
module tb_sift_detection_fifo_reader;
  import sift_fifo_reader_pkg::*;

  localparam int W  = 16;
  localparam int BL = 16;
  localparam int UW = 15;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [UW-1:0] usedw_drv = '0;
  logic          read_en;
  logic          data_en = 1'b0;
  logic          data = 1'b0;
  logic [W-1:0]  word;
  logic          valid;
  logic          ready = 1'b1;
  logic          busy;
  logic          flush = 1'b0;

  sift_detection_fifo_reader #(
    .WORD_W    (W),
    .BURST_LEN (BL),
    .USEDW_W   (UW)
  ) dut (
    .iclk     (clk),
    .ireset   (rst_n),
    .iusedw   (usedw_drv),
    .oread_en (read_en),
    .idata_en (data_en),
    .idata    (data),
    .oword    (word),
    .ovalid   (valid),
    .iready   (ready),
    .obusy    (busy)
`ifdef SIFT_FIFO_READER_FLUSH_EN
    ,
    .iflush   (flush)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  bit           src_bits[$];
  bit           model_bits[$];
  logic [W-1:0] got_words[$];
  logic [W-1:0] exp_words[$];
  int           exp_reads;
  int           read_count = 0;
  int           drop_a = -1, drop_b = -1;
  int           ready_mode = 0;
  int           bp_cnt = 0;
  int           stall_cycles = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // FIFO controller model: one data beat per accepted read, a cycle later.
  initial begin
    bit rd;
    bit b;
    forever begin
      @(negedge clk);
      rd = read_en;
      @(posedge clk);
      #1;
      if (rd && rst_n) begin
        b = (src_bits.size() > 0) ? src_bits.pop_front() : 1'b0;
        data_en = (read_count != drop_a) && (read_count != drop_b);
        data = b;
        read_count++;
      end else begin
        data_en = 1'b0;
        data = 1'b0;
      end
    end
  end

  // Downstream ready: 0 always ready, 1 random, 2 stall ten cycles on the fourth word.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0: ready = 1'b1;
        1: ready = 1'($urandom_range(0, 1));
        default: begin
          if (valid && got_words.size() == 3 && bp_cnt < 10) begin
            ready = 1'b0;
            bp_cnt++;
          end else begin
            ready = 1'b1;
          end
        end
      endcase
    end
  end

  // Output monitor: collects accepted words and checks hold behaviour under stall.
  initial begin
    bit           held = 1'b0;
    logic [W-1:0] held_word = '0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (held) begin
          check("hold ovalid", 32'(valid), 32'd1);
          check("hold oword", 32'(word), 32'(held_word));
        end
        if (valid) check("oread_en low while presenting", 32'(read_en), 32'd0);
        held = valid && !ready;
        held_word = word;
        if (valid && !ready) stall_cycles++;
        if (valid && ready) got_words.push_back(word);
      end else begin
        held = 1'b0;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic load_pattern(input logic [W-1:0] pattern);
    src_bits.delete();
    for (int r = 0; r < 320; r++) src_bits.push_back(pattern[W-1-(r%W)]);
    model_bits = src_bits;
  endtask

  task automatic load_random();
    src_bits.delete();
    for (int r = 0; r < 320; r++) src_bits.push_back(1'($urandom_range(0, 1)));
    model_bits = src_bits;
  endtask

  // Reference: list the per-word bit counts, then deal the stream out MSB-first.
  function automatic void model_burst(input int usedw, input bit do_flush);
    int           targets[$];
    int           nwords, r, pos;
    logic [W-1:0] w;
    exp_words.delete();
    if (usedw >= BL * W) begin
      for (int i = 0; i < BL; i++) targets.push_back(W);
    end else if (do_flush && usedw > 0) begin
      nwords = (usedw + W - 1) / W;
      for (int i = 0; i < nwords; i++)
        targets.push_back((i == nwords - 1 && usedw % W != 0) ? usedw % W : W);
    end
    r = 0;
    foreach (targets[i]) begin
      w = '0;
      pos = 0;
      for (int k = 0; k < targets[i]; k++) begin
        if (r != drop_a && r != drop_b) begin
          w[W-1-pos] = model_bits[r];
          pos++;
        end
        r++;
      end
      exp_words.push_back(w);
    end
    exp_reads = r;
  endfunction

  task automatic run_burst(input string tag, input int usedw, input bit do_flush);
    int cnt;
    int busy_cycles;
    model_burst(usedw, do_flush);
    read_count = 0;
    got_words.delete();
    stall_cycles = 0;
    bp_cnt = 0;
    usedw_drv = UW'(usedw);
    flush = do_flush;
    tick();
    flush = 1'b0;
    if (exp_reads > 0) begin
      cnt = 0;
      while (!busy && cnt < 4) begin tick(); cnt++; end
      usedw_drv = '0;
      cnt = 0;
      while (busy && cnt < 5000) begin tick(); cnt++; end
      check({tag, " burst completes"}, 32'(busy), 32'd0);
    end else begin
      busy_cycles = 0;
      repeat (100) begin
        if (busy || read_en) busy_cycles++;
        tick();
      end
      usedw_drv = '0;
      check({tag, " stays idle"}, 32'(busy_cycles), 32'd0);
    end
    repeat (3) tick();
    check({tag, " read pulses"}, 32'(read_count), 32'(exp_reads));
    check({tag, " word count"}, 32'(got_words.size()), 32'(exp_words.size()));
    for (int i = 0; i < got_words.size() && i < exp_words.size(); i++)
      check($sformatf("%s word%0d", tag, i), 32'(got_words[i]), 32'(exp_words[i]));
  endtask

  typedef struct {
    int           usedw;
    logic [W-1:0] pattern;
    int           drop_a;
    int           drop_b;
    int           exp_reads;
    int           exp_nwords;
    logic [W-1:0] exp_first;
    logic [W-1:0] exp_last;
  } vec_t;

  vec_t tv[7];

  initial begin
    int cnt;
    tv[0] = '{256,   16'hA5C3, -1,  -1,  256, 16, 16'hA5C3, 16'hA5C3};
    tv[1] = '{255,   16'hFFFF, -1,  -1,  0,   0,  16'h0000, 16'h0000};
    tv[2] = '{300,   16'hFFFF, 3,   9,   256, 16, 16'hFFFC, 16'hFFFF};
    tv[3] = '{0,     16'hFFFF, -1,  -1,  0,   0,  16'h0000, 16'h0000};
    tv[4] = '{32767, 16'h8001, -1,  -1,  256, 16, 16'h8001, 16'h8001};
    tv[5] = '{20,    16'hFFFF, -1,  -1,  0,   0,  16'h0000, 16'h0000};
    tv[6] = '{256,   16'h1237, 254, 255, 256, 16, 16'h1237, 16'h1234};

    // Reset state
    #12;
    check("reset oread_en", 32'(read_en), 32'd0);
    check("reset ovalid", 32'(valid), 32'd0);
    check("reset obusy", 32'(busy), 32'd0);
    check("reset oword", 32'(word), 32'd0);
    tick();
    rst_n = 1'b1;
    repeat (2) tick();

    // Trigger-to-first-ovalid latency
    load_pattern(16'hA5C3);
    read_count = 0;
    got_words.delete();
    usedw_drv = UW'(256);
    cnt = 0;
    do begin
      tick();
      cnt++;
      usedw_drv = '0;
    end while (!valid && cnt < 40);
    check("first ovalid latency", 32'(cnt), 32'(W + 2));
    cnt = 0;
    while (busy && cnt < 2000) begin tick(); cnt++; end
    check("latency burst completes", 32'(busy), 32'd0);
    check("latency burst reads", 32'(read_count), 32'd256);
    repeat (2) tick();

    // Reset in the middle of READ
    load_pattern(16'hFFFF);
    read_count = 0;
    usedw_drv = UW'(300);
    cnt = 0;
    while (read_count < 5 && cnt < 30) begin tick(); cnt++; end
    check("reads before reset", 32'(read_count), 32'd5);
    rst_n = 1'b0;
    #1;
    check("midburst reset oread_en", 32'(read_en), 32'd0);
    check("midburst reset ovalid", 32'(valid), 32'd0);
    check("midburst reset obusy", 32'(busy), 32'd0);
    check("midburst reset oword", 32'(word), 32'd0);
    usedw_drv = '0;
    tick();
    check("held reset obusy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    cnt = 0;
    repeat (20) begin tick(); if (busy) cnt++; end
    check("no restart after reset", 32'(cnt), 32'd0);

    // Vector table
    ready_mode = 0;
    foreach (tv[i]) begin
      load_pattern(tv[i].pattern);
      drop_a = tv[i].drop_a;
      drop_b = tv[i].drop_b;
      run_burst($sformatf("vec%0d", i), tv[i].usedw, 1'b0);
      check($sformatf("vec%0d table reads", i), 32'(read_count), 32'(tv[i].exp_reads));
      check($sformatf("vec%0d table words", i), 32'(got_words.size()), 32'(tv[i].exp_nwords));
      if (tv[i].exp_nwords > 0 && got_words.size() > 0) begin
        check($sformatf("vec%0d first word", i), 32'(got_words[0]), 32'(tv[i].exp_first));
        check($sformatf("vec%0d last word", i), 32'(got_words[$]), 32'(tv[i].exp_last));
      end
    end
    drop_a = -1;
    drop_b = -1;

    // Backpressure on the fourth word
    ready_mode = 2;
    load_pattern(16'hA5C3);
    run_burst("backpressure", 256, 1'b0);
    check("backpressure stall cycles", 32'(stall_cycles), 32'd10);
    ready_mode = 0;

`ifdef SIFT_FIFO_READER_FLUSH_EN
    load_pattern(16'hFFFF);
    run_burst("flush20", 20, 1'b1);
    check("flush20 reads", 32'(read_count), 32'd20);
    if (got_words.size() == 2) begin
      check("flush20 word0", 32'(got_words[0]), 32'h0000FFFF);
      check("flush20 word1", 32'(got_words[1]), 32'h0000F000);
    end
    load_pattern(16'hFFFF);
    run_burst("flush40", 40, 1'b1);
    run_burst("flush0", 0, 1'b1);
`endif

    // Randomized bursts with random ready and occasional dropped beats
    ready_mode = 1;
    for (int it = 0; it < 4; it++) begin
      load_random();
      drop_a = (it % 2 == 1) ? int'($urandom_range(0, 255)) : -1;
      drop_b = -1;
      run_burst($sformatf("rand%0d", it), int'($urandom_range(256, 32767)), 1'b0);
    end
    ready_mode = 0;
    drop_a = -1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sift_detection_fifo_reader.md
SIFT_DETECTION_FIFO_READER -- requirements
Module: sift_detection_fifo_reader

Interface
REQ-001 SHALL have parameter WORD_W, default 16: bits packed per output word.
REQ-002 SHALL have parameter BURST_LEN, default 16: words drained per burst.
REQ-003 SHALL have parameter USEDW_W, default 15: width of the FIFO fill-level input.
REQ-004 SHALL have port iclk  in  1: clock; all logic on the rising edge.
REQ-005 SHALL have port ireset  in  1: reset, asynchronous, active-low.
REQ-006 SHALL have port iusedw  in  USEDW_W: detection FIFO fill level, in bits.
REQ-007 SHALL have port oread_en  out  1: read request to the detection FIFO controller.
REQ-008 SHALL have port idata_en  in  1: read-data valid, one cycle after an accepted read.
REQ-009 SHALL have port idata  in  1: detection bit, qualified by idata_en.
REQ-010 SHALL have port oword  out  WORD_W: packed word.
REQ-011 SHALL have port ovalid  out  1: oword valid.
REQ-012 SHALL have port iready  in  1: downstream accepts oword.
REQ-013 SHALL have port obusy  out  1: high in every state except IDLE.
REQ-014 SHALL have port iflush  in  1: partial-drain request. Present only under SIFT_FIFO_READER_FLUSH_EN.

Function
REQ-015 SHALL use states IDLE, READ, LAST, PRESENT.
REQ-016 IDLE->READ SHALL occur when iusedw >= BURST_LEN*WORD_W, computed without truncation. The word counter and bit target SHALL load BURST_LEN and WORD_W.
REQ-017 READ SHALL assert oread_en for exactly bit-target consecutive cycles, then go to LAST.
REQ-018 LAST SHALL last one cycle to absorb the final idata_en, then go to PRESENT.
REQ-019 Each idata_en SHALL shift idata into the packing register MSB-first. The first bit of a word lands in oword[WORD_W-1].
REQ-020 In PRESENT, ovalid SHALL be 1 and oword SHALL be held stable until iready=1.
REQ-021 On the ovalid&iready cycle, the block SHALL decrement the word counter. It SHALL go to READ if the counter is nonzero, else to IDLE.
REQ-022 Bits shifted per word SHALL equal the number of idata_en pulses received. Missing pulses leave zeros in the unfilled LSBs; no error is flagged.
REQ-023 iready outside PRESENT SHALL be ignored.
REQ-024 oread_en SHALL be registered. Minimum time from the IDLE trigger to the first ovalid is WORD_W+2 cycles.
REQ-025 Between words of a burst, oread_en SHALL be low during LAST and PRESENT.

Reset
REQ-026 ireset low SHALL force the state to IDLE and clear oread_en, ovalid, obusy, oword, and all counters. This applies immediately, including mid-burst.
REQ-027 Bits in flight at reset SHALL be discarded. After release, the block SHALL wait for a fresh IDLE trigger.

Configuration
REQ-028 With SIFT_FIFO_READER_FLUSH_EN defined, iflush=1 in IDLE with 0 < iusedw < BURST_LEN*WORD_W SHALL start a flush burst. Word count = ceil(iusedw/WORD_W). The last word's bit target = iusedw mod WORD_W (WORD_W if 0). Unread LSBs = 0.
REQ-029 iflush SHALL be ignored outside IDLE and when iusedw = 0.
REQ-030 Without the macro, the iflush port and flush logic SHALL be absent, and sub-threshold data SHALL remain in the FIFO.

Structure
REQ-031 Package sift_fifo_reader_pkg SHALL hold the state enum type and the defaults for WORD_W and BURST_LEN.
REQ-032 Sub-module sift_bit_packer SHALL contain the shift register and received-bit counter. It SHALL have a clear input and a word-register output.

Verification
REQ-033 Reset mid-READ (iusedw=300, drop ireset after 5 reads) -> next cycle: oread_en=0, ovalid=0, obusy=0, state IDLE.
REQ-034 iusedw=256, FIFO model returns 0xA5C3 pattern repeated, iready=1 -> exactly 256 oread_en pulses, 16 words each 0xA5C3, then IDLE.
REQ-035 iusedw=255 -> no oread_en for 100 cycles, obusy=0.
REQ-036 Backpressure: iready low 10 cycles on word 3 -> oword stable and ovalid held, oread_en=0 throughout, burst completes with 16 words.
REQ-037 FLUSH_EN, iusedw=20, iflush pulse, bits all 1 -> words 0xFFFF then 0xF000, 20 read pulses.
REQ-038 Missing idata_en on 2 of 16 reads (bits all 1) -> word 0xFFFC, no hang.
